// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle cpu: opcodes, ALU operations and
// instruction field positions.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  // Instruction field bit positions
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RA_MSB  = 25;
  localparam int RA_LSB  = 21;
  localparam int RB_MSB  = 20;
  localparam int RB_LSB  = 16;
  localparam int RC_MSB  = 15;
  localparam int RC_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int JT_MSB  = 25;

  // Opcodes
  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000001;
  localparam logic [5:0] OP_MOV  = 6'b010000;
  localparam logic [5:0] OP_ADD  = 6'b010010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_OR   = 6'b010100;
  localparam logic [5:0] OP_AND  = 6'b010101;
  localparam logic [5:0] OP_SLT  = 6'b010111;
  localparam logic [5:0] OP_ADDI = 6'b110010;
  localparam logic [5:0] OP_SUBI = 6'b110011;
  localparam logic [5:0] OP_ORI  = 6'b110100;
  localparam logic [5:0] OP_ANDI = 6'b110101;
  localparam logic [5:0] OP_SLTI = 6'b110111;
  localparam logic [5:0] OP_LI   = 6'b111001;
  localparam logic [5:0] OP_LWI  = 6'b111011;
  localparam logic [5:0] OP_SWI  = 6'b111100;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b100001;

  // ALU operations; ALU_PASS_B forwards operand b (moves, immediates, addresses)
  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_OR     = 3'd2,
    ALU_AND    = 3'd3,
    ALU_SLT    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU; wraps modulo 2^32, no flags.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result
);

  // Select the operation result
  always_comb begin
    // NOTE: every path assigns result (default first), so no latch is inferred.
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Single-cycle word-addressed cpu: loadable instruction memory, 32x32
// register file, small data memory. One instruction retires per clock
// while start is high.
module cpu
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        I_MEM_Write_Enable,
  input  logic [31:0] I_MEM_Data_In,
  input  logic [15:0] I_MEM_Write_Addr,
  output logic [31:0] ALUOut,
  output logic [31:0] PC_out
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [NUM_REGS];

  logic [XLEN-1:0] pc, pc_next, instr;
  logic [5:0]      op;
  logic [4:0]      ra, rb, rc;
  logic [15:0]     imm;
  logic [XLEN-1:0] simm, zimm, rd_a, rd_b, rd_c;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_result, wb_data;
  logic            reg_we, mem_we, mem_rd, br_eq, br_ne, jump, out_zero;
  logic            branch_taken;

  // Only the low address bits select an IMEM word
  logic            unused_waddr;
  assign unused_waddr = ^I_MEM_Write_Addr[15:IW];

  // Fetch and field extraction
  assign instr = imem[pc[IW-1:0]];
  assign op    = instr[OP_MSB:OP_LSB];
  assign ra    = instr[RA_MSB:RA_LSB];
  assign rb    = instr[RB_MSB:RB_LSB];
  assign rc    = instr[RC_MSB:RC_LSB];
  assign imm   = instr[IMM_MSB:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};

  // Register reads are combinational; r0 always reads zero
  assign rd_a = (ra == 5'd0) ? '0 : regs[ra];
  assign rd_b = (rb == 5'd0) ? '0 : regs[rb];
  assign rd_c = (rc == 5'd0) ? '0 : regs[rc];

  // Decode: ALU operands and control for the instruction at PC
  always_comb begin
    alu_op   = ALU_ADD;
    alu_a    = rd_b;
    alu_b    = rd_c;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    mem_rd   = 1'b0;
    br_eq    = 1'b0;
    br_ne    = 1'b0;
    jump     = 1'b0;
    out_zero = 1'b0;
    case (op)
      OP_MOV:  begin alu_op = ALU_PASS_B; alu_b = rd_b; reg_we = 1'b1; end
      OP_ADD:  begin alu_op = ALU_ADD; reg_we = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; reg_we = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  reg_we = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; reg_we = 1'b1; end
      OP_SLT:  begin alu_op = ALU_SLT; reg_we = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; alu_b = simm; reg_we = 1'b1; end
      OP_SUBI: begin alu_op = ALU_SUB; alu_b = simm; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = zimm; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; alu_b = zimm; reg_we = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; alu_b = simm; reg_we = 1'b1; end
      OP_LI:   begin alu_op = ALU_PASS_B; alu_b = zimm; reg_we = 1'b1; end
      OP_LWI:  begin alu_op = ALU_PASS_B; alu_b = zimm; reg_we = 1'b1; mem_rd = 1'b1; end
      OP_SWI:  begin alu_op = ALU_PASS_B; alu_b = zimm; mem_we = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; alu_a = rd_a; alu_b = rd_b; br_eq = 1'b1; end
      OP_BNE:  begin alu_op = ALU_SUB; alu_a = rd_a; alu_b = rd_b; br_ne = 1'b1; end
      OP_J:    begin jump = 1'b1; out_zero = 1'b1; end
      default: out_zero = 1'b1;  // NOP and undefined opcodes
    endcase
  end

  cpu_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result)
  );

  assign wb_data      = mem_rd ? dmem[imm[DW-1:0]] : alu_result;
  assign branch_taken = (br_eq && (rd_a == rd_b)) || (br_ne && (rd_a != rd_b));

  // Next-PC selection: sequential, jump or relative branch
  always_comb begin
    pc_next = pc + 32'd1;
    if (jump)
      pc_next = {6'b000000, instr[JT_MSB:0]};
    else if (branch_taken)
      pc_next = pc + 32'd1 + simm;
  end

  assign ALUOut = (!rst || out_zero) ? '0 : alu_result;
  assign PC_out = pc;

  // IMEM load port, independent of reset and start
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so a same-cycle fetch of this word still sees the old value.
    // NOTE: memories are deliberately not reset; only PC and registers are.
    if (I_MEM_Write_Enable)
      imem[I_MEM_Write_Addr[IW-1:0]] <= I_MEM_Data_In;
  end

  // PC and register file: synchronous reset, otherwise advance when started
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (start) begin
      pc <= pc_next;
      if (reg_we && (ra != 5'd0))
        regs[ra] <= wb_data;
    end
  end

  // Data memory store port
  always_ff @(posedge clk) begin
    if (rst && start && mem_we)
      dmem[imm[DW-1:0]] <= rd_a;
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed program table, reset/load sequences
// and a randomized run compared against an instruction-level reference model.
module tb_cpu;

  localparam logic [5:0] K_NOP = 6'h00, K_J = 6'h01, K_MOV = 6'h10, K_ADD = 6'h12,
                         K_SUB = 6'h13, K_OR = 6'h14, K_AND = 6'h15, K_SLT = 6'h17,
                         K_ADDI = 6'h32, K_SUBI = 6'h33, K_ORI = 6'h34, K_ANDI = 6'h35,
                         K_SLTI = 6'h37, K_LI = 6'h39, K_LWI = 6'h3B, K_SWI = 6'h3C,
                         K_BEQ = 6'h20, K_BNE = 6'h21;

  logic        clk = 1'b0;
  logic        rst, start, we;
  logic [31:0] din;
  logic [15:0] waddr;
  logic [31:0] alu_out, pc_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .I_MEM_Write_Enable (we),
    .I_MEM_Data_In      (din),
    .I_MEM_Write_Addr   (waddr),
    .ALUOut             (alu_out),
    .PC_out             (pc_out)
  );

  // Reference model state
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  typedef struct {
    bit          start;
    logic [31:0] pc;
    logic [31:0] alu;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input int a, input int b, input int c);
    return {op, 5'(a), 5'(b), 5'(c), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int a, input int b, input logic [15:0] imm);
    return {op, 5'(a), 5'(b), imm};
  endfunction

  // Execute the instruction at m_pc; returns the expected ALUOut and, when
  // commit is set, applies its architectural effects.
  task automatic model_exec(input bit commit, output logic [31:0] alu);
    logic [31:0] ins, ra, rb, rc, simm, zimm, npc, val;
    logic [4:0]  a;
    logic [15:0] imm;
    bit          wr;
    ins  = m_imem[m_pc[7:0]];
    a    = ins[25:21];
    imm  = ins[15:0];
    ra   = m_regs[ins[25:21]];
    rb   = m_regs[ins[20:16]];
    rc   = m_regs[ins[15:11]];
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0, imm};
    npc  = m_pc + 1;
    alu  = 0;
    val  = 0;
    wr   = 0;
    case (ins[31:26])
      K_MOV:  begin val = rb;      wr = 1; end
      K_ADD:  begin val = rb + rc; wr = 1; end
      K_SUB:  begin val = rb - rc; wr = 1; end
      K_OR:   begin val = rb | rc; wr = 1; end
      K_AND:  begin val = rb & rc; wr = 1; end
      K_SLT:  begin val = ($signed(rb) < $signed(rc)) ? 1 : 0; wr = 1; end
      K_ADDI: begin val = rb + simm; wr = 1; end
      K_SUBI: begin val = rb - simm; wr = 1; end
      K_ORI:  begin val = rb | zimm; wr = 1; end
      K_ANDI: begin val = rb & zimm; wr = 1; end
      K_SLTI: begin val = ($signed(rb) < $signed(simm)) ? 1 : 0; wr = 1; end
      K_LI:   begin val = zimm; wr = 1; end
      K_LWI:  begin alu = zimm; val = m_dmem[imm[7:0]]; wr = 1; end
      K_SWI:  begin alu = zimm; if (commit) m_dmem[imm[7:0]] = ra; end
      K_BEQ:  begin alu = ra - rb; if (ra == rb) npc = m_pc + 1 + simm; end
      K_BNE:  begin alu = ra - rb; if (ra != rb) npc = m_pc + 1 + simm; end
      K_J:    npc = {6'b0, ins[25:0]};
      default: ;
    endcase
    if (wr && ins[31:26] != K_LWI) alu = val;
    if (commit) begin
      if (wr && a != 0) m_regs[a] = val;
      m_pc = npc;
    end
  endtask

  // One clock: drive inputs, sample outputs mid-cycle, compare with the
  // model, then advance the model past the coming rising edge.
  task automatic cycle(input bit rst_v, input bit start_v, input bit we_v,
                       input logic [15:0] addr, input logic [31:0] data,
                       output logic [31:0] s_pc, output logic [31:0] s_alu);
    logic [31:0] e_alu;
    @(negedge clk);
    rst = rst_v; start = start_v; we = we_v; waddr = addr; din = data;
    #1;
    s_pc  = pc_out;
    s_alu = alu_out;
    model_exec(1'b0, e_alu);
    check("model_pc", s_pc, m_pc);
    check("model_alu", s_alu, rst_v ? e_alu : 32'd0);
    if (!rst_v) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else if (start_v) begin
      model_exec(1'b1, e_alu);
    end
    if (we_v) m_imem[addr[7:0]] = data;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [15:0] imm;
    logic [2:0]  r;
    imm = 16'($urandom);
    r   = 3'($urandom);
    case ($urandom_range(0, 19))
      0: op = K_NOP;   1: op = K_J;     2: op = K_MOV;   3: op = K_ADD;
      4: op = K_SUB;   5: op = K_OR;    6: op = K_AND;   7: op = K_SLT;
      8: op = K_ADDI;  9: op = K_SUBI;  10: op = K_ORI;  11: op = K_ANDI;
      12: op = K_SLTI; 13: op = K_LI;   14: op = K_LWI;  15: op = K_SWI;
      16: op = K_BEQ;  17: op = K_BNE;  18: op = 6'h3F;  default: op = 6'h02;
    endcase
    if (op == K_J)
      return {op, ($urandom_range(0, 3) == 0) ? 26'($urandom) : 26'($urandom_range(0, 255))};
    if (op == K_LWI || op == K_SWI) imm = {8'($urandom), 5'b0, r};
    if (op == K_BEQ || op == K_BNE) imm = {{13{r[2]}}, r};
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), imm[10:0]};
  endfunction

  logic [31:0] prog [27];
  vec_t        vec  [33];
  logic [31:0] s_pc, s_alu;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; we = 1'b0; waddr = '0; din = '0;
    m_pc = 0;
    for (int i = 0; i < 256; i++) begin m_imem[i] = 0; m_dmem[i] = 0; end
    for (int i = 0; i < 32; i++) m_regs[i] = 0;

    prog[0]  = ri(K_ADDI, 1, 0, 16'h0005);
    prog[1]  = ri(K_ADDI, 2, 0, 16'h000A);
    prog[2]  = ri(K_ADDI, 3, 0, 16'hFFF8);
    prog[3]  = ri(K_SUBI, 4, 0, 16'h0001);
    prog[4]  = ri(K_ORI,  5, 0, 16'hAAAA);
    prog[5]  = ri(K_ANDI, 6, 5, 16'h5555);
    prog[6]  = rr(K_MOV,  7, 1, 0);
    prog[7]  = rr(K_MOV,  8, 2, 0);
    prog[8]  = rr(K_ADD,  9, 6, 0);
    prog[9]  = rr(K_SUB, 11, 1, 2);
    prog[10] = rr(K_OR,  10, 1, 2);
    prog[11] = rr(K_AND, 12, 10, 7);
    prog[12] = rr(K_ADD, 13, 7, 7);
    prog[13] = rr(K_OR,   0, 1, 2);
    prog[14] = ri(K_BEQ, 12, 13, 16'hFFF1);
    prog[15] = ri(K_BEQ,  8, 13, 16'h0001);
    prog[16] = ri(K_LI,  13, 0, 16'hBEEF);
    prog[17] = ri(K_SWI, 13, 0, 16'h0008);
    prog[18] = ri(K_LWI, 14, 0, 16'h0008);
    prog[19] = ri(K_BNE, 13, 14, 16'h0005);
    prog[20] = ri(K_ADDI, 15, 0, 16'h0008);
    prog[21] = ri(K_BNE, 12, 14, 16'h0001);
    prog[22] = ri(K_LI,  15, 0, 16'h000B);
    prog[23] = rr(K_SLT, 16, 11, 1);
    prog[24] = ri(K_SLTI, 17, 1, 16'hFFFB);
    prog[25] = ri(K_SLTI, 18, 11, 16'h0000);
    prog[26] = {K_J, 26'd0};

    vec = '{
      '{1'b0, 32'd0,  32'h5},        '{1'b0, 32'd0,  32'h5},        '{1'b0, 32'd0,  32'h5},
      '{1'b1, 32'd0,  32'h5},        '{1'b1, 32'd1,  32'hA},        '{1'b1, 32'd2,  32'hFFFFFFF8},
      '{1'b1, 32'd3,  32'hFFFFFFFF}, '{1'b1, 32'd4,  32'hAAAA},     '{1'b1, 32'd5,  32'h0},
      '{1'b1, 32'd6,  32'h5},        '{1'b1, 32'd7,  32'hA},        '{1'b1, 32'd8,  32'h0},
      '{1'b1, 32'd9,  32'hFFFFFFFB}, '{1'b1, 32'd10, 32'hF},        '{1'b1, 32'd11, 32'h5},
      '{1'b1, 32'd12, 32'hA},        '{1'b1, 32'd13, 32'hF},        '{1'b1, 32'd14, 32'hFFFFFFFB},
      '{1'b1, 32'd15, 32'h0},        '{1'b1, 32'd17, 32'h8},        '{1'b1, 32'd18, 32'h8},
      '{1'b1, 32'd19, 32'h0},        '{1'b1, 32'd20, 32'h8},        '{1'b1, 32'd21, 32'hFFFFFFFB},
      '{1'b1, 32'd23, 32'h1},        '{1'b1, 32'd24, 32'h0},        '{1'b1, 32'd25, 32'h1},
      '{1'b1, 32'd26, 32'h0},        '{1'b1, 32'd0,  32'h5},        '{1'b0, 32'd1,  32'hA},
      '{1'b0, 32'd1,  32'hA},        '{1'b1, 32'd1,  32'hA},        '{1'b1, 32'd2,  32'hFFFFFFF8}
    };

    // Load the program while held in reset
    for (int i = 0; i < 27; i++) cycle(1'b0, 1'b0, 1'b1, 16'(i), prog[i], s_pc, s_alu);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("reset_pc", s_pc, 32'd0);
    check("reset_alu", s_alu, 32'd0);

    // Directed program table
    for (int i = 0; i < 33; i++) begin
      cycle(1'b1, vec[i].start, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
      check($sformatf("vec%0d_pc", i), s_pc, vec[i].pc);
      check($sformatf("vec%0d_alu", i), s_alu, vec[i].alu);
    end

    // Mid-run reset clears PC and registers; IMEM loads still work in reset
    cycle(1'b0, 1'b1, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("midrst_pc_before", s_pc, 32'd3);
    check("midrst_alu_forced", s_alu, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0300, rr(K_ADD, 2, 1, 10), s_pc, s_alu);
    check("midrst_pc", s_pc, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0001, rr(K_OR, 3, 16, 18), s_pc, s_alu);
    check("midrst_alu", s_alu, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("regs_cleared_a", s_alu, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("hold_pc", s_pc, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("regs_cleared_b", s_alu, 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
    check("after_rst_pc2", s_pc, 32'd2);
    check("after_rst_alu2", s_alu, 32'hFFFFFFF8);

    // Random program: words 0..7 zero DMEM[0..7] so every load is defined
    for (int i = 0; i < 256; i++)
      cycle(1'b0, 1'b0, 1'b1, 16'(i),
            (i < 8) ? ri(K_SWI, 0, 0, 16'(i)) : rand_instr(), s_pc, s_alu);
    for (int i = 0; i < 3000; i++) begin
      if (i < 8) begin
        cycle(1'b1, 1'b1, 1'b0, 16'd0, 32'd0, s_pc, s_alu);
      end else begin
        cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 1) == 1) ? {8'($urandom), m_pc[7:0]} : 16'($urandom),
              rand_instr(), s_pc, s_alu);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
